// File: rtl/repeat_delay_sched_if.sv
// rtl/repeat_delay_sched_if.sv - request and write-port bundle for the delayed-write scheduler
interface repeat_delay_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8,
  parameter int SLOTS  = 4
);
  logic                         req_valid;
  logic                         req_ready;
  logic [CNT_W-1:0]             req_count;
  logic [ADDR_W-1:0]            req_addr;
  logic [DATA_W-1:0]            req_data;
  logic                         wr_valid;
  logic                         wr_ready;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic [$clog2(SLOTS+1)-1:0]   pending;
  logic                         busy;

  modport master (
    output req_valid, req_count, req_addr, req_data, wr_ready,
    input  req_ready, wr_valid, wr_addr, wr_data, pending, busy
  );

  modport slave (
    input  req_valid, req_count, req_addr, req_data, wr_ready,
    output req_ready, wr_valid, wr_addr, wr_data, pending, busy
  );
endinterface

// File: rtl/repeat_delay_sched.sv
// rtl/repeat_delay_sched.sv - repeat(N) @(posedge clk) delayed-write scheduler with sticky-grant issue
// Optional: REPEAT_SCHED_EVENT_GATE_EN adds ev_tick so WAIT counters only advance on qualified edges.
module repeat_delay_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8,
  parameter int SLOTS  = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef REPEAT_SCHED_EVENT_GATE_EN
  input  logic ev_tick,
`endif
  repeat_delay_sched_if.slave bus
);
  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PEND_W = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DUE  = 2'd2
  } slot_state_t;

  slot_state_t       r_state [SLOTS];
  logic [CNT_W-1:0]  r_cnt   [SLOTS];
  logic [ADDR_W-1:0] r_addr  [SLOTS];
  logic [DATA_W-1:0] r_data  [SLOTS];
  logic              r_hold;
  logic [IDX_W-1:0]  r_gnt_idx;
  logic [PEND_W-1:0] r_pending;

  logic              w_free_any;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_due_any;
  logic [IDX_W-1:0]  w_due_idx;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_wr_valid;
  logic              w_accept;
  logic              w_fire;
  logic              w_tick;

`ifdef REPEAT_SCHED_EVENT_GATE_EN
  assign w_tick = ev_tick;
`else
  assign w_tick = 1'b1;
`endif

  // Descending scan so the last hit wins, leaving the lowest index selected.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_due_any  = 1'b0;
    w_due_idx  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (r_state[i] == S_IDLE) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_state[i] == S_DUE) begin
        w_due_any = 1'b1;
        w_due_idx = IDX_W'(i);
      end
    end
  end

  assign w_gnt_idx  = r_hold ? r_gnt_idx : w_due_idx;
  assign w_wr_valid = r_hold | w_due_any;
  assign w_accept   = bus.req_valid & w_free_any;
  assign w_fire     = w_wr_valid & bus.wr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
      end
      r_hold    <= 1'b0;
      r_gnt_idx <= '0;
      r_pending <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_accept && (w_free_idx == IDX_W'(i))) begin
              r_addr[i]  <= bus.req_addr;
              r_data[i]  <= bus.req_data;
              r_cnt[i]   <= bus.req_count;
              r_state[i] <= (bus.req_count == '0) ? S_DUE : S_WAIT;
            end
          end
          S_WAIT: begin
            // Counter never reaches zero in WAIT, so a max count cannot wrap.
            if (w_tick) begin
              if (r_cnt[i] == CNT_W'(1)) r_state[i] <= S_DUE;
              else                       r_cnt[i]   <= r_cnt[i] - CNT_W'(1);
            end
          end
          S_DUE: begin
            if (w_fire && (w_gnt_idx == IDX_W'(i))) r_state[i] <= S_IDLE;
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end

      // Grant is frozen while the presented write is stalled.
      r_hold <= w_wr_valid & ~bus.wr_ready;
      if (w_wr_valid && !bus.wr_ready) r_gnt_idx <= w_gnt_idx;

      case ({w_accept, w_fire})
        2'b10:   r_pending <= r_pending + PEND_W'(1);
        2'b01:   r_pending <= r_pending - PEND_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign bus.req_ready = w_free_any;
  assign bus.wr_valid  = w_wr_valid;
  assign bus.wr_addr   = w_wr_valid ? r_addr[w_gnt_idx] : '0;
  assign bus.wr_data   = w_wr_valid ? r_data[w_gnt_idx] : '0;
  assign bus.pending   = r_pending;
  assign bus.busy      = (r_pending != '0);
endmodule

// File: tb/tb_repeat_delay_sched.sv
// tb/tb_repeat_delay_sched.sv - directed and randomized checks of repeat_delay_sched against a timestamp model
module tb_repeat_delay_sched;
  localparam int SLOTS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ev_tick = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  repeat_delay_sched_if #(.DATA_W(32), .ADDR_W(4), .CNT_W(8), .SLOTS(SLOTS)) bus ();

  repeat_delay_sched #(.DATA_W(32), .ADDR_W(4), .CNT_W(8), .SLOTS(SLOTS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef REPEAT_SCHED_EVENT_GATE_EN
    .ev_tick (ev_tick),
`endif
    .bus     (bus)
  );

  // Model: a slot is due once (qualified edges since acceptance) >= N.
  bit          m_used [SLOTS];
  int          m_base [SLOTS];
  int          m_n    [SLOTS];
  int          m_addr [SLOTS];
  int unsigned m_data [SLOTS];
  int          m_ticks;
  bit          m_hold;
  int          m_gidx;

  bit          p_ready, p_valid;
  int          p_gidx;
  int          p_addr;
  int unsigned p_data;
  int          p_pending;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) m_used[i] = 1'b0;
    m_hold = 1'b0;
    m_gidx = 0;
  endtask

  task automatic predict();
    bit due_any;
    int due_idx;
    due_any = 1'b0;
    due_idx = 0;
    p_ready = 1'b0;
    p_pending = 0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!m_used[i]) p_ready = 1'b1;
      else p_pending++;
      if (m_used[i] && (m_ticks - m_base[i] >= m_n[i])) begin
        due_any = 1'b1;
        due_idx = i;
      end
    end
    p_valid = m_hold || due_any;
    p_gidx  = m_hold ? m_gidx : due_idx;
    p_addr  = p_valid ? m_addr[p_gidx] : 0;
    p_data  = p_valid ? m_data[p_gidx] : 0;
  endtask

  task automatic cycle(input bit rstn_i, input bit rv, input int cnt, input int addr,
                       input int unsigned data, input bit wrr, input bit ev);
    bit fire, acc, tick;
    int free_idx;
    rst_n         = rstn_i;
    bus.req_valid = rv;
    bus.req_count = cnt[7:0];
    bus.req_addr  = addr[3:0];
    bus.req_data  = data;
    bus.wr_ready  = wrr;
    ev_tick       = ev;
`ifdef REPEAT_SCHED_EVENT_GATE_EN
    tick = ev;
`else
    tick = 1'b1;
`endif
    predict();
    if (!rstn_i) begin
      model_clear();
    end else begin
      fire = p_valid && wrr;
      acc  = rv && p_ready;
      free_idx = 0;
      for (int i = SLOTS - 1; i >= 0; i--) if (!m_used[i]) free_idx = i;
      if (tick) m_ticks++;
      if (fire) m_used[p_gidx] = 1'b0;
      if (acc) begin
        m_used[free_idx] = 1'b1;
        m_base[free_idx] = m_ticks;
        m_n[free_idx]    = cnt & 255;
        m_addr[free_idx] = addr & 15;
        m_data[free_idx] = data;
      end
      m_hold = p_valid && !wrr;
      m_gidx = p_gidx;
    end
    @(posedge clk);
    #1;
    predict();
    check_eq("req_ready", bus.req_ready, p_ready);
    check_eq("wr_valid",  bus.wr_valid,  p_valid);
    check_eq("wr_addr",   bus.wr_addr,   p_addr);
    check_eq("wr_data",   bus.wr_data,   p_data);
    check_eq("pending",   bus.pending,   p_pending);
    check_eq("busy",      bus.busy,      p_pending != 0);
  endtask

  task automatic idle(input bit wrr);
    cycle(1'b1, 1'b0, 0, 0, 32'd99, wrr, 1'b1);
  endtask

  initial begin
    int          q_addr[$];
    int unsigned q_data[$];
    int          seen;
    m_ticks = 0;
    model_clear();
    bus.req_valid = 1'b0;
    bus.req_count = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.wr_ready  = 1'b0;

    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1);
    check_eq("rst_wr_valid", bus.wr_valid, 0);
    check_eq("rst_req_ready", bus.req_ready, 1);
    check_eq("rst_pending", bus.pending, 0);
    check_eq("rst_busy", bus.busy, 0);

    // N=3, data captured at acceptance, later upstream data ignored
    cycle(1'b1, 1'b1, 3, 2, 32'd42, 1'b1, 1'b1);
    check_eq("n3_e0_valid", bus.wr_valid, 0);
    idle(1'b1);
    idle(1'b1);
    check_eq("n3_e2_valid", bus.wr_valid, 0);
    idle(1'b1);
    check_eq("n3_e3_valid", bus.wr_valid, 1);
    check_eq("n3_addr", bus.wr_addr, 2);
    check_eq("n3_data", bus.wr_data, 42);
    idle(1'b1);
    check_eq("n3_pending_done", bus.pending, 0);

    // N=0 with backpressure
    cycle(1'b1, 1'b1, 0, 1, 32'd7, 1'b0, 1'b1);
    check_eq("n0_valid", bus.wr_valid, 1);
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      check_eq("n0_hold_valid", bus.wr_valid, 1);
      check_eq("n0_hold_data", bus.wr_data, 7);
      check_eq("n0_hold_pending", bus.pending, 1);
    end
    idle(1'b1);
    check_eq("n0_drained", bus.pending, 0);

    // Four back-to-back requests, issue order by due time then index
    cycle(1'b1, 1'b1, 5, 0, 32'h100, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 5, 1, 32'h101, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2, 2, 32'h102, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8, 3, 32'h103, 1'b0, 1'b1);
    check_eq("full_ready", bus.req_ready, 0);
    for (int k = 0; k < 8; k++) idle(1'b0);
    for (int k = 0; k < 20; k++) begin
      if (bus.wr_valid) q_addr.push_back(int'(bus.wr_addr));
      idle(1'b1);
    end
    check_eq("order_cnt", q_addr.size(), 4);
    if (q_addr.size() == 4) begin
      check_eq("order_0", q_addr[0], 2);
      check_eq("order_1", q_addr[1], 0);
      check_eq("order_2", q_addr[2], 1);
      check_eq("order_3", q_addr[3], 3);
    end

    // Slot freed at an edge is not reallocated on that same edge
    for (int i = 0; i < SLOTS; i++) cycle(1'b1, 1'b1, 0, i, 32'd100 + i, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 0, 9, 32'd200, 1'b1, 1'b1);
    check_eq("free_pending", bus.pending, 3);
    check_eq("free_ready", bus.req_ready, 1);
    cycle(1'b1, 1'b1, 0, 9, 32'd200, 1'b0, 1'b1);
    check_eq("realloc_pending", bus.pending, 4);
    for (int k = 0; k < 12; k++) begin
      if (bus.wr_valid) q_data.push_back(bus.wr_data);
      idle(1'b1);
    end
    check_eq("realloc_cnt", q_data.size(), 4);
    if (q_data.size() == 4) begin
      check_eq("realloc_0", q_data[0], 101);
      check_eq("realloc_1", q_data[1], 200);
      check_eq("realloc_2", q_data[2], 102);
      check_eq("realloc_3", q_data[3], 103);
    end

    // Reset mid-operation drops everything
    cycle(1'b1, 1'b1, 0, 5, 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 20, 6 + i, 32'd2 + i, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    check_eq("mrst_valid", bus.wr_valid, 0);
    check_eq("mrst_pending", bus.pending, 0);
    check_eq("mrst_ready", bus.req_ready, 1);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      idle(1'b1);
      if (bus.wr_valid) seen++;
    end
    check_eq("mrst_no_issue", seen, 0);

`ifdef REPEAT_SCHED_EVENT_GATE_EN
    cycle(1'b1, 1'b1, 3, 4, 32'd55, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, (k % 2) == 1);
      check_eq("ev_due", bus.wr_valid, k >= 5);
    end
    idle(1'b1);
    idle(1'b1);
`endif

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 199) != 0,
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 40) == 0) ? 255 : int'($urandom_range(0, 6)),
            int'($urandom_range(0, 15)),
            $urandom,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
